tpg_stream_gen: RTL and testbench
=================================

// Module: tpg_stream_gen
// PURPOSE
//   Parametrised test-pattern generator; next generation of the incrementing TPG. Emits one
//   control packet then one frame of video per frame period on valid/ready streams, with
//   run-time selectable pattern, frame size and SOF/EOL markers. Sits at the head of a video
//   pipeline as a stimulus source for downstream VIP blocks.
// PARAMETERS
//   BPC       8   bits per colour component
//   CHANNELS  3   components per pixel (1..4)
//   SQ_LOG2   5   checkerboard square size = 2**SQ_LOG2 pixels
// PORTS
//   clk           in   1              clock; all logic on rising edge
//   rst_n         in   1              asynchronous, active-low reset
//   en            in   1              run enable; sampled at frame boundaries only
//   mode          in   2              0 incrementing, 1 colour bars, 2 solid, 3 checkerboard
//   cfg_width     in   16             active pixels per line
//   cfg_height    in   16             active lines per frame
//   solid_color   in   CHANNELS*BPC   pixel value for mode 2
//   ctrl_valid    out  1              control packet valid
//   ctrl_ready    in   1              control packet accepted
//   ctrl_data     out  36             {width[15:0], height[15:0], 4'h0}
//   vid_valid     out  1              pixel valid
//   vid_ready     in   1              downstream accepts pixel
//   vid_data      out  CHANNELS*BPC   pixel; channel 0 in LSBs
//   vid_sof       out  1              first pixel of frame (x=0,y=0)
//   vid_eol       out  1              last pixel of line (x=width-1)
//   frame_cnt     out  16             completed frames, wraps 0xFFFF->0
//   cfg_err       out  1              sticky: en seen with width or height = 0
// BEHAVIOUR
//   - Reset: FSM IDLE; all outputs 0, incl. ctrl_data, frame_cnt, cfg_err; x=y=0.
//   - FSM IDLE->CTRL: en=1 and width,height != 0; same edge latches mode, width, height,
//     solid_color, bar_w=width>>3 (min 1). en=1 with a zero dimension: stay IDLE, set cfg_err.
//   - CTRL: ctrl_valid=1, ctrl_data from latched cfg; held stable until ctrl_ready.
//     Accept cycle -> ACTIVE; first pixel valid the next cycle (1-cycle latency).
//   - ACTIVE: vid_valid=1; vid_data/sof/eol registered and held stable while !vid_ready.
//     Pixel advances only on vid_valid&vid_ready. x wraps at width-1 and y increments;
//     on last pixel (x=w-1,y=h-1) accepted: frame_cnt+1, x=y=0; en=1 -> CTRL (re-latch cfg,
//     no idle cycle on ctrl_valid), else -> IDLE with vid_valid=0 next cycle.
//   - en dropped mid-frame: frame completes; cfg inputs changed mid-frame: ignored.
//   - ctrl_valid and vid_valid never high together; no pixel lost or duplicated on stalls.
//   - Patterns (per channel c, all ones = {BPC{1'b1}}):
//     mode0: c0=x[BPC-1:0], c1=y[BPC-1:0], c2..=frame_cnt[BPC-1:0] (truncate, no saturate).
//     mode1: 8 bars; bar idx steps every bar_w pixels, saturates at 7, resets per line;
//            c0=idx[2], c1=idx[1], c2=idx[0] each expanded to all ones/zero; c3=0.
//     mode2: solid_color latched at frame start.
//     mode3: (x[SQ_LOG2]^y[SQ_LOG2]) ? all ones : 0 on every channel.
//   - width=1: every pixel has vid_eol; width=height=1: vid_sof and vid_eol on same pixel.
//   - rst_n asserted mid-frame: immediate return to reset state; no partial-frame flush.
// TESTING
//   1. mode0, 4x2, ready=1, en=1 -> ctrl {16'd4,16'd2,4'h0}, then 8 pixels, c0=0,1,2,3,0..,
//      c1=0 x4 then 1 x4, sof on px0, eol on px3 and px7, frame_cnt=1.
//   2. mode1, width 16 -> idx steps every 2 px: px0-1 = 0x000000, px14-15 = 0xFFFFFF (BPC 8).
//   3. Random vid_ready/ctrl_ready stalls, mode3 64x64 -> data stable under stall, 4096
//      pixels in raster order, checker flips at x=32 and y=32.
//   4. en=1 with cfg_width=0 -> no ctrl_valid, cfg_err=1; set width=8 -> frame starts.
//   5. Drop en at pixel 10 of 8x4 frame -> all 32 pixels sent, then IDLE, frame_cnt=1;
//      change mode mid-frame -> no effect until next frame.
//   6. Assert rst_n=0 mid-frame -> all outputs 0 asynchronously; restart begins with ctrl packet.

Source files
------------

// File: rtl/tpg_stream_if.sv
// Valid/ready stream bundle for the test-pattern generator: one control
// packet channel and one pixel channel, both driven by the generator.
interface tpg_stream_if #(
  parameter int DW = 24
);
  logic          ctrl_valid;
  logic          ctrl_ready;
  logic [35:0]   ctrl_data;
  logic          vid_valid;
  logic          vid_ready;
  logic [DW-1:0] vid_data;
  logic          vid_sof;
  logic          vid_eol;

  modport master (
    output ctrl_valid, ctrl_data, vid_valid, vid_data, vid_sof, vid_eol,
    input  ctrl_ready, vid_ready
  );

  modport slave (
    input  ctrl_valid, ctrl_data, vid_valid, vid_data, vid_sof, vid_eol,
    output ctrl_ready, vid_ready
  );
endinterface

// File: rtl/tpg_stream_gen.sv
// Test-pattern generator: per frame, one control packet carrying the frame
// size, then width*height pixels in raster order. The pattern, frame size
// and solid colour are latched at each frame start, so mid-frame changes
// on the configuration inputs have no effect.
module tpg_stream_gen #(
  parameter int BPC      = 8,
  parameter int CHANNELS = 3,
  parameter int SQ_LOG2  = 5
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_en,
  input  logic [1:0]               i_mode,
  input  logic [15:0]              i_cfg_width,
  input  logic [15:0]              i_cfg_height,
  input  logic [CHANNELS*BPC-1:0]  i_solid_color,
  tpg_stream_if.master             stream,
  output logic [15:0]              o_frame_cnt,
  output logic                     o_cfg_err
);

  localparam int DW = CHANNELS * BPC;

  typedef enum logic [1:0] {IDLE, CTRL, ACTIVE} state_t;

  state_t          r_state;
  logic [1:0]      r_mode;
  logic [15:0]     r_width;
  logic [15:0]     r_height;
  logic [DW-1:0]   r_solid;
  logic [15:0]     r_barW;
  logic [15:0]     r_x;
  logic [15:0]     r_y;
  logic [15:0]     r_barCnt;
  logic [2:0]      r_barIdx;
  logic [15:0]     r_frameCnt;
  logic            r_cfgErr;
  logic            r_ctrlValid;
  logic [35:0]     r_ctrlData;
  logic            r_vidValid;
  logic [DW-1:0]   r_vidData;
  logic            r_vidSof;
  logic            r_vidEol;

  logic            w_cfgOk;
  logic            w_lastX;
  logic            w_lastY;
  logic            w_lastPx;
  logic            w_startFrame;
  logic [15:0]     w_barW;
  logic [15:0]     w_nextX;
  logic [15:0]     w_nextY;
  logic [15:0]     w_nextBarCnt;
  logic [2:0]      w_nextBarIdx;

  // Pixel value for position (px,py) in bar idx, using the latched frame
  // configuration and the count of frames already completed.
  function automatic logic [DW-1:0] makePixel(input logic [15:0] px,
                                              input logic [15:0] py,
                                              input logic [2:0]  idx);
    logic [DW-1:0]  pix;
    logic [BPC-1:0] ch;
    logic           chk;
    logic           bar;
    pix = '0;
    chk = px[SQ_LOG2] ^ py[SQ_LOG2];
    for (int c = 0; c < CHANNELS; c++) begin
      bar = (c == 0) ? idx[2] : (c == 1) ? idx[1] : (c == 2) ? idx[0] : 1'b0;
      case (r_mode)
        2'd0:    ch = (c == 0) ? px[BPC-1:0] : (c == 1) ? py[BPC-1:0] : r_frameCnt[BPC-1:0];
        2'd1:    ch = {BPC{bar}};
        2'd2:    ch = r_solid[c*BPC +: BPC];
        default: ch = {BPC{chk}};
      endcase
      pix[c*BPC +: BPC] = ch;
    end
    return pix;
  endfunction

  // Raster position of the pixel following the one currently presented,
  // plus the bar counter that saturates at bar 7 and restarts every line.
  always_comb begin
    w_cfgOk      = i_en && (i_cfg_width != 16'd0) && (i_cfg_height != 16'd0);
    w_barW       = (i_cfg_width[15:3] == 13'd0) ? 16'd1 : {3'b000, i_cfg_width[15:3]};
    w_lastX      = (r_x == r_width - 16'd1);
    w_lastY      = (r_y == r_height - 16'd1);
    w_lastPx     = w_lastX && w_lastY;
    w_nextX      = w_lastX ? 16'd0 : r_x + 16'd1;
    w_nextY      = w_lastX ? r_y + 16'd1 : r_y;
    w_nextBarCnt = r_barCnt + 16'd1;
    w_nextBarIdx = r_barIdx;
    if (w_lastX) begin
      w_nextBarCnt = 16'd0;
      w_nextBarIdx = 3'd0;
    end else if (r_barCnt + 16'd1 == r_barW) begin
      w_nextBarCnt = 16'd0;
      w_nextBarIdx = (r_barIdx == 3'd7) ? 3'd7 : r_barIdx + 3'd1;
    end
    w_startFrame = w_cfgOk && ((r_state == IDLE) ||
                   ((r_state == ACTIVE) && stream.vid_ready && w_lastPx));
  end

  // Capture the frame configuration whenever a new frame is launched.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mode     <= 2'd0;
      r_width    <= 16'd0;
      r_height   <= 16'd0;
      r_solid    <= '0;
      r_barW     <= 16'd0;
      r_ctrlData <= 36'd0;
    end else if (w_startFrame) begin
      r_mode     <= i_mode;
      r_width    <= i_cfg_width;
      r_height   <= i_cfg_height;
      r_solid    <= i_solid_color;
      r_barW     <= w_barW;
      r_ctrlData <= {i_cfg_width, i_cfg_height, 4'h0};
    end
  end

  // Frame sequencer with registered stream outputs; pixels only advance on
  // an accepted transfer, so stalls neither drop nor repeat pixels.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_x         <= 16'd0;
      r_y         <= 16'd0;
      r_barCnt    <= 16'd0;
      r_barIdx    <= 3'd0;
      r_frameCnt  <= 16'd0;
      r_cfgErr    <= 1'b0;
      r_ctrlValid <= 1'b0;
      r_vidValid  <= 1'b0;
      r_vidData   <= '0;
      r_vidSof    <= 1'b0;
      r_vidEol    <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_cfgOk) begin
            r_ctrlValid <= 1'b1;
            r_state     <= CTRL;
          end else if (i_en) begin
            r_cfgErr    <= 1'b1;
          end
        end
        CTRL: begin
          if (stream.ctrl_ready) begin
            r_ctrlValid <= 1'b0;
            r_vidValid  <= 1'b1;
            r_x         <= 16'd0;
            r_y         <= 16'd0;
            r_barCnt    <= 16'd0;
            r_barIdx    <= 3'd0;
            r_vidData   <= makePixel(16'd0, 16'd0, 3'd0);
            r_vidSof    <= 1'b1;
            r_vidEol    <= (r_width == 16'd1);
            r_state     <= ACTIVE;
          end
        end
        ACTIVE: begin
          if (stream.vid_ready) begin
            if (w_lastPx) begin
              r_frameCnt <= r_frameCnt + 16'd1;
              r_x        <= 16'd0;
              r_y        <= 16'd0;
              r_vidValid <= 1'b0;
              r_vidSof   <= 1'b0;
              r_vidEol   <= 1'b0;
              if (w_cfgOk) begin
                r_ctrlValid <= 1'b1;
                r_state     <= CTRL;
              end else begin
                if (i_en) r_cfgErr <= 1'b1;
                r_state <= IDLE;
              end
            end else begin
              r_x       <= w_nextX;
              r_y       <= w_nextY;
              r_barCnt  <= w_nextBarCnt;
              r_barIdx  <= w_nextBarIdx;
              r_vidData <= makePixel(w_nextX, w_nextY, w_nextBarIdx);
              r_vidSof  <= 1'b0;
              r_vidEol  <= (w_nextX == r_width - 16'd1);
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign stream.ctrl_valid = r_ctrlValid;
  assign stream.ctrl_data  = r_ctrlData;
  assign stream.vid_valid  = r_vidValid;
  assign stream.vid_data   = r_vidData;
  assign stream.vid_sof    = r_vidSof;
  assign stream.vid_eol    = r_vidEol;
  assign o_frame_cnt       = r_frameCnt;
  assign o_cfg_err         = r_cfgErr;

endmodule

// File: tb/tb_tpg_stream_gen.sv
// Directed bench for tpg_stream_gen: packet contents, pattern values,
// stall behaviour, configuration errors, en handling and async reset.
module tb_tpg_stream_gen;
  localparam int DW = 24;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          en;
  logic [1:0]    mode;
  logic [15:0]   cfgWidth;
  logic [15:0]   cfgHeight;
  logic [DW-1:0] solidColor;
  logic [15:0]   frameCnt;
  logic          cfgErr;

  int testCount = 0;
  int failCount = 0;

  logic [35:0]   ctrlData;
  logic [DW-1:0] pixData;
  logic          pixSof;
  logic          pixEol;
  int            waitCycles;

  logic [DW-1:0] t1Exp [8];
  logic [DW-1:0] barExp [8];

  tpg_stream_if #(.DW(DW)) bus ();

  tpg_stream_gen #(.BPC(8), .CHANNELS(3), .SQ_LOG2(5)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_en          (en),
    .i_mode        (mode),
    .i_cfg_width   (cfgWidth),
    .i_cfg_height  (cfgHeight),
    .i_solid_color (solidColor),
    .stream        (bus),
    .o_frame_cnt   (frameCnt),
    .o_cfg_err     (cfgErr)
  );

  // Free-running 100 MHz clock.
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    testCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
    end
  endtask

  task automatic finishBench();
    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  endtask

  task automatic applyStimulus(input logic e, input logic [1:0] m,
                               input logic [15:0] w, input logic [15:0] h,
                               input logic [DW-1:0] s);
    en = e; mode = m; cfgWidth = w; cfgHeight = h; solidColor = s;
  endtask

  // Wait for and accept one control packet, then drop ctrl_ready again.
  task automatic receiveCtrl(input bit randReady, output logic [35:0] data);
    bit got = 0;
    data = '0;
    for (int i = 0; i < 200 && !got; i++) begin
      @(negedge clk);
      bus.ctrl_ready = randReady ? 1'($urandom_range(0, 1)) : 1'b1;
      if (bus.ctrl_valid && bus.ctrl_ready) begin
        data = bus.ctrl_data;
        got  = 1;
      end
    end
    if (!got) begin
      checkOutput("ctrl_timeout", 0, 1);
      finishBench();
    end
    @(posedge clk);
    #1 bus.ctrl_ready = 1'b0;
  endtask

  // Wait for and accept one pixel; while stalled the presented pixel must hold.
  task automatic receivePixel(input bit randReady, output logic [DW-1:0] data,
                              output logic sof, output logic eol, output int cycles);
    bit got = 0;
    bit haveHeld = 0;
    logic [DW+1:0] held = '0;
    data = '0; sof = 0; eol = 0; cycles = 0;
    while (!got) begin
      @(negedge clk);
      cycles++;
      if (cycles > 200) begin
        checkOutput("pixel_timeout", 0, 1);
        finishBench();
      end
      if (haveHeld)
        checkOutput("stall_stable", {bus.vid_valid, bus.vid_sof, bus.vid_eol, bus.vid_data},
                    {1'b1, held});
      bus.vid_ready = randReady ? 1'($urandom_range(0, 1)) : 1'b1;
      if (bus.vid_valid && bus.vid_ready) begin
        data = bus.vid_data; sof = bus.vid_sof; eol = bus.vid_eol;
        got  = 1;
        checkOutput("exclusive_valid", bus.ctrl_valid, 0);
      end else if (bus.vid_valid) begin
        haveHeld = 1;
        held     = {bus.vid_sof, bus.vid_eol, bus.vid_data};
      end
    end
  endtask

  // Hard stop in case the sequence below stops making progress.
  initial begin
    #900000;
    checkOutput("watchdog", 0, 1);
    finishBench();
  end

  initial begin
    t1Exp  = '{24'h000000, 24'h000001, 24'h000002, 24'h000003,
               24'h000100, 24'h000101, 24'h000102, 24'h000103};
    barExp = '{24'h000000, 24'hFF0000, 24'h00FF00, 24'hFFFF00,
               24'h0000FF, 24'hFF00FF, 24'h00FFFF, 24'hFFFFFF};

    // Reset state
    rst_n = 1'b0;
    applyStimulus(0, 2'd0, 16'd0, 16'd0, 24'd0);
    bus.ctrl_ready = 1'b0;
    bus.vid_ready  = 1'b0;
    #23;
    @(negedge clk) rst_n = 1'b1;
    @(negedge clk);
    checkOutput("rst_ctrl_valid", bus.ctrl_valid, 0);
    checkOutput("rst_vid_valid", bus.vid_valid, 0);
    checkOutput("rst_ctrl_data", bus.ctrl_data, 0);
    checkOutput("rst_vid_data", bus.vid_data, 0);
    checkOutput("rst_frame_cnt", frameCnt, 0);
    checkOutput("rst_cfg_err", cfgErr, 0);

    // Test 1: incrementing 4x2
    applyStimulus(1, 2'd0, 16'd4, 16'd2, 24'hABCDEF);
    receiveCtrl(0, ctrlData);
    en = 1'b0;
    checkOutput("t1_ctrl", ctrlData, {16'd4, 16'd2, 4'h0});
    for (int p = 0; p < 8; p++) begin
      receivePixel(0, pixData, pixSof, pixEol, waitCycles);
      if (p == 0) checkOutput("t1_latency", waitCycles, 1);
      checkOutput("t1_data", pixData, t1Exp[p]);
      checkOutput("t1_sof", pixSof, (p == 0));
      checkOutput("t1_eol", pixEol, (p == 3 || p == 7));
    end
    repeat (3) @(negedge clk);
    checkOutput("t1_frame_cnt", frameCnt, 1);
    checkOutput("t1_idle_vid", bus.vid_valid, 0);
    checkOutput("t1_idle_ctrl", bus.ctrl_valid, 0);

    // Test 2: colour bars, width 20 so bar_w=2 and bars 8/9 saturate at 7
    applyStimulus(1, 2'd1, 16'd20, 16'd1, 24'd0);
    receiveCtrl(0, ctrlData);
    en = 1'b0;
    checkOutput("t2_ctrl", ctrlData, {16'd20, 16'd1, 4'h0});
    for (int p = 0; p < 20; p++) begin
      receivePixel(0, pixData, pixSof, pixEol, waitCycles);
      checkOutput("t2_data", pixData, barExp[(p / 2 > 7) ? 7 : p / 2]);
      checkOutput("t2_sof", pixSof, (p == 0));
      checkOutput("t2_eol", pixEol, (p == 19));
    end
    repeat (3) @(negedge clk);
    checkOutput("t2_frame_cnt", frameCnt, 2);

    // Test 3: checkerboard 64x64 with random stalls on both channels
    applyStimulus(1, 2'd3, 16'd64, 16'd64, 24'd0);
    receiveCtrl(1, ctrlData);
    en = 1'b0;
    checkOutput("t3_ctrl", ctrlData, {16'd64, 16'd64, 4'h0});
    for (int y = 0; y < 64; y++) begin
      for (int x = 0; x < 64; x++) begin
        receivePixel(1, pixData, pixSof, pixEol, waitCycles);
        checkOutput("t3_data", pixData, (((x >> 5) ^ (y >> 5)) & 1) != 0 ? 24'hFFFFFF : 24'h0);
        checkOutput("t3_sof", pixSof, (x == 0 && y == 0));
        checkOutput("t3_eol", pixEol, (x == 63));
      end
    end
    repeat (3) @(negedge clk);
    checkOutput("t3_frame_cnt", frameCnt, 3);

    // Test 4: zero width flags an error, then a valid width starts a frame
    bus.vid_ready = 1'b1;
    applyStimulus(1, 2'd2, 16'd0, 16'd4, 24'h123456);
    repeat (5) @(negedge clk);
    checkOutput("t4_no_ctrl", bus.ctrl_valid, 0);
    checkOutput("t4_cfg_err", cfgErr, 1);
    cfgWidth  = 16'd8;
    cfgHeight = 16'd1;
    receiveCtrl(0, ctrlData);
    en         = 1'b0;
    solidColor = 24'h654321;
    checkOutput("t4_ctrl", ctrlData, {16'd8, 16'd1, 4'h0});
    for (int p = 0; p < 8; p++) begin
      receivePixel(0, pixData, pixSof, pixEol, waitCycles);
      checkOutput("t4_data", pixData, 24'h123456);
      checkOutput("t4_eol", pixEol, (p == 7));
    end
    repeat (3) @(negedge clk);
    checkOutput("t4_frame_cnt", frameCnt, 4);
    checkOutput("t4_cfg_err_sticky", cfgErr, 1);

    // Test 5: en dropped and config changed mid-frame, frame still completes
    applyStimulus(1, 2'd0, 16'd8, 16'd4, 24'd0);
    receiveCtrl(0, ctrlData);
    checkOutput("t5_ctrl", ctrlData, {16'd8, 16'd4, 4'h0});
    for (int p = 0; p < 32; p++) begin
      if (p == 10) begin
        en = 1'b0; mode = 2'd3; cfgWidth = 16'd2;
      end
      receivePixel(0, pixData, pixSof, pixEol, waitCycles);
      checkOutput("t5_data", pixData, {8'd4, 8'(p / 8), 8'(p % 8)});
      checkOutput("t5_eol", pixEol, ((p % 8) == 7));
    end
    repeat (4) @(negedge clk);
    checkOutput("t5_idle_vid", bus.vid_valid, 0);
    checkOutput("t5_idle_ctrl", bus.ctrl_valid, 0);
    checkOutput("t5_frame_cnt", frameCnt, 5);

    // Test 6a: 1x1 frames, back-to-back control packet with en held
    applyStimulus(1, 2'd0, 16'd1, 16'd1, 24'd0);
    receiveCtrl(0, ctrlData);
    checkOutput("t6_ctrl", ctrlData, {16'd1, 16'd1, 4'h0});
    receivePixel(0, pixData, pixSof, pixEol, waitCycles);
    checkOutput("t6_data", pixData, 24'h050000);
    checkOutput("t6_sof", pixSof, 1);
    checkOutput("t6_eol", pixEol, 1);
    @(negedge clk);
    checkOutput("t6_b2b_ctrl", bus.ctrl_valid, 1);
    checkOutput("t6_b2b_vid", bus.vid_valid, 0);
    checkOutput("t6_frame_cnt", frameCnt, 6);
    en = 1'b0;
    receiveCtrl(0, ctrlData);
    checkOutput("t6_ctrl2", ctrlData, {16'd1, 16'd1, 4'h0});
    receivePixel(0, pixData, pixSof, pixEol, waitCycles);
    checkOutput("t6_data2", pixData, 24'h060000);
    checkOutput("t6_sof2", pixSof, 1);

    // Test 6b: asynchronous reset mid-frame, restart begins with ctrl packet
    applyStimulus(1, 2'd0, 16'd8, 16'd4, 24'd0);
    receiveCtrl(0, ctrlData);
    for (int p = 0; p < 5; p++)
      receivePixel(0, pixData, pixSof, pixEol, waitCycles);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("t6_rst_vid_valid", bus.vid_valid, 0);
    checkOutput("t6_rst_ctrl_valid", bus.ctrl_valid, 0);
    checkOutput("t6_rst_vid_data", bus.vid_data, 0);
    checkOutput("t6_rst_ctrl_data", bus.ctrl_data, 0);
    checkOutput("t6_rst_frame_cnt", frameCnt, 0);
    checkOutput("t6_rst_cfg_err", cfgErr, 0);
    @(negedge clk) rst_n = 1'b1;
    receiveCtrl(0, ctrlData);
    checkOutput("t6_restart_ctrl", ctrlData, {16'd8, 16'd4, 4'h0});
    receivePixel(0, pixData, pixSof, pixEol, waitCycles);
    checkOutput("t6_restart_latency", waitCycles, 1);
    checkOutput("t6_restart_data", pixData, 24'h000000);
    checkOutput("t6_restart_sof", pixSof, 1);
    en = 1'b0;

    finishBench();
  end

endmodule
